sound_mixer: RTL and testbench
==============================

Name: sound_mixer

Overview:
Parametrised N-channel mixer for the analog-sound path. Each channel has an unsigned sample, an enable and a gain. Per-channel volume ramps remove clicks when a channel is switched on or off. A time-multiplexed sequencer multiplies and accumulates the channels, then scales and saturates the sum into the signed 16-bit audio word that feeds the audio output stage.

Parameters:
NUM_CH, 4, number of input channels (1..16)
IN_W, 4, channel sample width (unsigned)
GAIN_W, 4, gain and level width (unsigned, 0..2^GAIN_W-1)
OUT_W, 16, output width (signed)
SHIFT, 5, left shift applied to the accumulated sum before saturation
FADE_DIV, 3000, clk_3MHz_en ticks per one-LSB level step (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
clk_3MHz_en  in  1  one-clk-wide sample/fade tick
ch_sample  in  NUM_CH*IN_W  channel samples; channel i at bits [i*IN_W +: IN_W]
ch_en  in  NUM_CH  channel enable (replaces the single motor_en gate)
ch_gain  in  NUM_CH*GAIN_W  target gain per channel
out  out  OUT_W  signed mixed sample (shortint when OUT_W=16)
out_valid  out  1  one-clk pulse when out updates
overrun  out  1  sticky: a tick arrived while a frame was in progress

Behaviour:
- Reset (any cycle, including mid-frame) forces:
  - out=0, out_valid=0, overrun=0
  - all levels=0, fade divider=0, state=IDLE, accumulator=0
  - an abandoned frame produces no output
- Fade divider:
  - counts clk_3MHz_en ticks 0..FADE_DIV-1
  - the tick at count FADE_DIV-1 wraps the count to 0 and raises a one-cycle step.
- Per-channel level:
  - target = ch_en[i] ? ch_gain[i] : 0
  - on each step, level moves exactly 1 toward target; holds when equal
  - a target change mid-ramp reverses direction at the next step; no jumps.
- FSM IDLE -> ACC -> OUT -> IDLE:
  - IDLE: clk_3MHz_en in cycle T starts a frame. All ch_sample are snapshotted at T, acc cleared, idx=0.
  - ACC: one channel per clk. acc += snap[idx]*level[idx], for cycles T+1..T+NUM_CH. Levels are read as registered values in each cycle; a level step coincident with T is visible from T+1.
  - OUT: cycle T+NUM_CH+1. out <= sat(acc<<SHIFT), out_valid=1. Back to IDLE at T+NUM_CH+2.
  - Latency: tick to out_valid = NUM_CH+1 clks. clk must run at least NUM_CH+2 times faster than the tick rate for full throughput.
- Overrun:
  - clk_3MHz_en in ACC or OUT is dropped for mixing and sets overrun until rst
  - the fade divider still counts every tick regardless of FSM state.
- Arithmetic:
  - product width IN_W+GAIN_W, unsigned
  - acc width IN_W+GAIN_W+clog2(NUM_CH)+1, unsigned, no overflow possible
  - scaled = acc<<SHIFT, computed wide
  - if scaled > 2^(OUT_W-1)-1, out = 2^(OUT_W-1)-1; else out = scaled
  - output is never negative
- out holds its value between frames; out_valid is low except in the OUT cycle.

Decomposition:
- Package sound_mix_pkg:
  - mix_state_t enum (IDLE, ACC, OUT)
  - functions for acc width and saturation limit
  - default parameter constants
- Sub-module sound_fade_ramp: one per channel, generated NUM_CH times. Ports clk, rst, step, target, level. The divider and FSM live in sound_mixer.

Test Plan:
- Reset: assert rst for 3 clks mid-frame with a non-zero mix -> out=0, out_valid=0, overrun=0, and no out_valid for the abandoned frame.
- Fade-in: FADE_DIV=1, ch0 sample=15, gain=15, en=1, others en=0, tick every 8 clks -> out rises 480 per frame (15*1*32, 15*2*32, ...) and plateaus at 7200 after 15 ticks; out_valid arrives 5 clks after each tick.
- Fade-out/reversal: from the plateau, drop en -> out falls by exactly 480 per frame to 0. Re-enable when level=7 -> level climbs 8, 9, ... with no step greater than 480.
- Saturation: SHIFT=6, all 4 channels sample=15, gain=15, levels settled -> acc=900, 57600 clamps so out=32767. With SHIFT=5 -> out=28800.
- Overrun: tick asserted every clk -> overrun=1 after the first frame, out_valid every NUM_CH+2=6 clks, and the level still ramps one step per tick with FADE_DIV=1.
- Gain retarget: ch1 en=1, gain 12 then 4 once level=12, FADE_DIV=2 -> level decrements one step every 2 ticks to 4 and holds; ch0 unaffected.

Source files
------------

// File: rtl/sound_mix_pkg.sv
// rtl/sound_mix_pkg.sv - shared types, defaults and width helpers for the channel mixer
package sound_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } mix_state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_IN_W     = 4;
  localparam int DEF_GAIN_W   = 4;
  localparam int DEF_OUT_W    = 16;
  localparam int DEF_SHIFT    = 5;
  localparam int DEF_FADE_DIV = 3000;

  // One spare bit above the worst-case sum keeps the accumulator overflow-free.
  function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
    return in_w + gain_w + $clog2(num_ch) + 1;
  endfunction

  function automatic longint unsigned sat_limit(input int out_w);
    return (64'd1 << (out_w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/sound_fade_ramp.sv
// rtl/sound_fade_ramp.sv - per-channel level that walks one LSB toward its target on each step
module sound_fade_ramp
  import sound_mix_pkg::*;
#(
  parameter int GAIN_W = DEF_GAIN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [GAIN_W-1:0] target,
  output logic [GAIN_W-1:0] level
);

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (step) begin
      if (level < target) begin
        level <= level + 1'b1;
      end else if (level > target) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_mixer.sv
// rtl/sound_mixer.sv - N-channel ramped mixer with time-multiplexed MAC and saturating output
module sound_mixer
  import sound_mix_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int IN_W     = DEF_IN_W,
  parameter int GAIN_W   = DEF_GAIN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int SHIFT    = DEF_SHIFT,
  parameter int FADE_DIV = DEF_FADE_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_3MHz_en,
  input  logic [NUM_CH*IN_W-1:0]   ch_sample,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  output logic signed [OUT_W-1:0]  out,
  output logic                     out_valid,
  output logic                     overrun
);

  localparam int ACC_W  = acc_width(IN_W, GAIN_W, NUM_CH);
  localparam int PROD_W = IN_W + GAIN_W;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam longint unsigned SAT_LIM = sat_limit(OUT_W);

  logic [DIV_W-1:0]       div_cnt;
  logic                   step;
  logic [GAIN_W-1:0]      level [NUM_CH];
  mix_state_t             state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_CH*IN_W-1:0] snap;
  logic [ACC_W-1:0]       acc, acc_nxt;
  logic [PROD_W-1:0]      prod;
  logic [63:0]            scaled;
  logic                   last_ch;

  // The divider sees every tick, including ticks dropped by a busy sequencer.
  assign step = clk_3MHz_en && (div_cnt == DIV_W'(FADE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clk_3MHz_en) begin
      div_cnt <= step ? '0 : div_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sound_fade_ramp #(.GAIN_W(GAIN_W)) u_ramp (
      .clk    (clk),
      .rst    (rst),
      .step   (step),
      .target (ch_en[i] ? ch_gain[i*GAIN_W +: GAIN_W] : '0),
      .level  (level[i])
    );
  end

  assign prod    = PROD_W'(snap[idx*IN_W +: IN_W]) * PROD_W'(level[idx]);
  assign acc_nxt = acc + ACC_W'(prod);
  assign last_ch = (idx == IDX_W'(NUM_CH - 1));
  assign scaled  = 64'(acc_nxt) << SHIFT;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clk_3MHz_en) state_nxt = ACC;
      ACC:     if (last_ch) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final sum is latched on the last ACC edge so out and out_valid appear together in OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      snap      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (clk_3MHz_en && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (clk_3MHz_en) begin
            snap <= ch_sample;
            acc  <= '0;
            idx  <= '0;
          end
        end
        ACC: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (last_ch) begin
            out       <= (scaled > SAT_LIM) ? $signed(OUT_W'(SAT_LIM)) : $signed(OUT_W'(scaled));
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// tb/tb_sound_mixer.sv - randomized and directed bench for sound_mixer against a cycle model
module tb_sound_mixer;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic [15:0]        ch_sample;
  logic [3:0]         ch_en;
  logic [15:0]        ch_gain;
  logic signed [15:0] out_a, out_b;
  logic               out_valid_a, out_valid_b;
  logic               overrun_a, overrun_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sound_mixer #(.NUM_CH(4), .IN_W(4), .GAIN_W(4), .OUT_W(16), .SHIFT(5), .FADE_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .clk_3MHz_en(tick), .ch_sample(ch_sample), .ch_en(ch_en),
    .ch_gain(ch_gain), .out(out_a), .out_valid(out_valid_a), .overrun(overrun_a)
  );

  sound_mixer #(.NUM_CH(4), .IN_W(4), .GAIN_W(4), .OUT_W(16), .SHIFT(6), .FADE_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .clk_3MHz_en(tick), .ch_sample(ch_sample), .ch_en(ch_en),
    .ch_gain(ch_gain), .out(out_b), .out_valid(out_valid_b), .overrun(overrun_b)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 mirrors dut_a (SHIFT 5, FADE_DIV 1), index 1 dut_b (SHIFT 6, FADE_DIV 2).
  int lvl   [2][4];
  int fsnap [2][4];
  int divc  [2];
  bit fact  [2];
  int fph   [2];
  int facc  [2];
  int e_out [2];
  bit e_val [2];
  bit e_ovr [2];

  function automatic int sat16(input int acc, input int sh);
    longint s;
    s = longint'(acc) << sh;
    return (s > 32767) ? 32767 : int'(s);
  endfunction

  task automatic model_edge(input int m);
    bit busy;
    bit stp;
    int tgt;
    if (rst) begin
      for (int i = 0; i < 4; i++) lvl[m][i] = 0;
      divc[m] = 0; fact[m] = 0; fph[m] = 0; facc[m] = 0;
      e_out[m] = 0; e_val[m] = 0; e_ovr[m] = 0;
      return;
    end
    e_val[m] = 0;
    busy = fact[m];
    if (fact[m]) begin
      fph[m]++;
      if (fph[m] <= 4) facc[m] += fsnap[m][fph[m]-1] * lvl[m][fph[m]-1];
      if (fph[m] == 4) begin
        e_out[m] = sat16(facc[m], (m == 1) ? 6 : 5);
        e_val[m] = 1;
      end
      if (fph[m] == 5) fact[m] = 0;
    end
    stp = 0;
    if (tick) begin
      divc[m]++;
      if (divc[m] == ((m == 1) ? 2 : 1)) begin
        stp = 1;
        divc[m] = 0;
      end
      if (busy) begin
        e_ovr[m] = 1;
      end else begin
        fact[m] = 1; fph[m] = 0; facc[m] = 0;
        for (int i = 0; i < 4; i++) fsnap[m][i] = int'(ch_sample[i*4 +: 4]);
      end
    end
    if (stp) begin
      for (int i = 0; i < 4; i++) begin
        tgt = ch_en[i] ? int'(ch_gain[i*4 +: 4]) : 0;
        if (lvl[m][i] < tgt) lvl[m][i]++;
        else if (lvl[m][i] > tgt) lvl[m][i]--;
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
    #1;
    check("out_a", int'(out_a), e_out[0]);
    check("valid_a", int'(out_valid_a), int'(e_val[0]));
    check("ovr_a", int'(overrun_a), int'(e_ovr[0]));
    check("out_b", int'(out_b), e_out[1]);
    check("valid_b", int'(out_valid_b), int'(e_val[1]));
    check("ovr_b", int'(overrun_b), int'(e_ovr[1]));
  end

  // One tick followed by seven idle clocks; reports tick-to-valid latency and the new outputs.
  task automatic do_tick(output int lat, output int va, output int vb);
    lat = -1; va = -1; vb = -1;
    tick = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      tick = 1'b0;
      if (lat < 0 && out_valid_a) begin
        lat = n;
        va  = int'(out_a);
        vb  = int'(out_b);
      end
    end
  endtask

  initial begin
    int lat, va, vb, prev, seen;
    rst = 1'b1; tick = 1'b0; ch_sample = '0; ch_en = '0; ch_gain = '0;
    repeat (3) @(negedge clk);
    check("rst_out_a", int'(out_a), 0);
    check("rst_valid_a", int'(out_valid_a), 0);
    check("rst_ovr_b", int'(overrun_b), 0);
    rst = 1'b0;
    @(negedge clk);

    ch_sample = 16'($urandom); ch_gain = 16'($urandom);
    ch_sample[3:0] = 4'd15; ch_gain[3:0] = 4'd15; ch_en = 4'b0001;
    for (int k = 1; k <= 18; k++) begin
      do_tick(lat, va, vb);
      check("fadein_lat", lat, 5);
      check("fadein_out", va, ((k < 15) ? k : 15) * 480);
    end

    ch_en[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      do_tick(lat, va, vb);
      check("fadeout_out", va, (15 - k) * 480);
    end
    ch_en[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      do_tick(lat, va, vb);
      check("reverse_out", va, (7 + k) * 480);
    end

    ch_sample = 16'hFFFF; ch_gain = 16'hFFFF; ch_en = 4'hF;
    for (int k = 0; k < 32; k++) do_tick(lat, va, vb);
    check("sat_shift5", va, 28800);
    check("sat_shift6", vb, 32767);

    ch_en[0] = 1'b0;
    tick = 1'b1; prev = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid_a) begin
        if (prev >= 0) check("ovr_gap", n - prev, 6);
        prev = n;
      end
    end
    tick = 1'b0;
    check("ovr_sticky_a", int'(overrun_a), 1);
    check("ovr_sticky_b", int'(overrun_b), 1);
    repeat (8) @(negedge clk);

    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1; seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid_a || out_valid_b) seen++;
    end
    check("midrst_out_a", int'(out_a), 0);
    check("midrst_out_b", int'(out_b), 0);
    check("midrst_ovr_a", int'(overrun_a), 0);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_a || out_valid_b) seen++;
    end
    check("midrst_no_valid", seen, 0);

    ch_sample = 16'($urandom); ch_gain = 16'($urandom);
    ch_sample[7:0] = 8'hF0; ch_gain[7:0] = 8'hC5; ch_en = 4'b0011;
    for (int k = 0; k < 24; k++) do_tick(lat, va, vb);
    check("retarget_plateau", vb, 11520);
    ch_gain[7:4] = 4'd4;
    for (int k = 0; k < 4; k++) do_tick(lat, va, vb);
    check("retarget_mid", vb, 9600);
    for (int k = 0; k < 16; k++) do_tick(lat, va, vb);
    check("retarget_hold", vb, 3840);
    check("retarget_ch0", int'(dut_b.g_ch[0].u_ramp.level), 5);
    check("retarget_ch1", int'(dut_b.g_ch[1].u_ramp.level), 4);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) begin
        ch_en     = 4'($urandom);
        ch_gain   = 16'($urandom);
        ch_sample = 16'($urandom);
      end
    end
    rst = 1'b0; tick = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
